// File: rtl/cmp_lt_slice_scheduler.sv
// Round-robin shared unsigned less-than comparator.
// One requester is granted at a time. Its operand pair is latched and
// compared SLICE bits per cycle, starting at the MSB slice. The first slice
// that differs ends the comparison early. The lt/eq result is returned
// together with the owning requester index.
//
// Handshake semantics, identical on both ports: a transfer happens on a
// rising edge where valid and ready are both high. A producer holds valid
// and its payload stable until that edge. Ready never depends on a
// transfer happening in the same cycle. On the request side, req_ready is
// one-hot or zero. On the response side, rsp_valid and its payload are held
// until rsp_ready is seen.
module cmp_lt_slice_scheduler #(
    parameter int WIDTH = 32,
    parameter int SLICE = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic                  rsp_lt,
    output logic                  rsp_eq,
    output logic [IDW-1:0]        rsp_id,
    output logic                  busy
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int SIW    = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [SIW-1:0] LAST_SLICE = SIW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMP  = 2'd1,
        RESP = 2'd2
    } state_t;

    // Current and next FSM state. Checkers can bind to these directly.
    state_t state;
    state_t state_d;

    logic [WIDTH-1:0] a_reg;
    logic [WIDTH-1:0] b_reg;
    logic [IDW-1:0]   id_reg;
    logic [IDW-1:0]   rr_ptr;
    logic [SIW-1:0]   slice_idx;
    logic             lt_reg;
    logic             eq_reg;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [IDW:0]     cand;
    logic             accept;
    logic             cmp_done;
    logic [SLICE-1:0] a_slice;
    logic [SLICE-1:0] b_slice;

    // Round-robin pick: first valid requester scanning upward from rr_ptr.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, rr_ptr} + (IDW + 1)'(k);
            if (cand >= (IDW + 1)'(NREQ)) begin
                cand = cand - (IDW + 1)'(NREQ);
            end
            if (!grant_found && req_valid[cand[IDW-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[IDW-1:0];
            end
        end
    end

    // The slice currently being compared, selected by slice_idx.
    always_comb begin
        a_slice = a_reg[int'(slice_idx) * SLICE +: SLICE];
        b_slice = b_reg[int'(slice_idx) * SLICE +: SLICE];
    end

    // Next-state logic and the grant strobe. Reset suppresses a grant so
    // no request is consumed on a reset edge.
    always_comb begin
        state_d   = state;
        req_ready = '0;
        accept    = 1'b0;
        cmp_done  = 1'b0;
        case (state)
            IDLE: begin
                if (grant_found && !rst) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_d              = CMP;
                end
            end
            CMP: begin
                if ((a_slice != b_slice) || (slice_idx == '0)) begin
                    cmp_done = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Operand latch, arbiter pointer, slice walk and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            a_reg     <= '0;
            b_reg     <= '0;
            id_reg    <= '0;
            rr_ptr    <= '0;
            slice_idx <= LAST_SLICE;
            lt_reg    <= 1'b0;
            eq_reg    <= 1'b0;
        end else begin
            if (accept) begin
                a_reg     <= req_a[int'(grant_idx) * WIDTH +: WIDTH];
                b_reg     <= req_b[int'(grant_idx) * WIDTH +: WIDTH];
                id_reg    <= grant_idx;
                rr_ptr    <= (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                slice_idx <= LAST_SLICE;
            end
            if (state == CMP) begin
                if (cmp_done) begin
                    lt_reg <= (a_slice < b_slice);
                    eq_reg <= (a_slice == b_slice);
                end else begin
                    slice_idx <= slice_idx - 1'b1;
                end
            end
        end
    end

    // Flags are forced low outside RESP so a stale result never leaks out.
    assign rsp_valid = (state == RESP);
    assign rsp_lt    = rsp_valid & lt_reg;
    assign rsp_eq    = rsp_valid & eq_reg;
    assign rsp_id    = id_reg;
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_cmp_lt_slice_scheduler.sv
// Bench for cmp_lt_slice_scheduler: directed cases followed by random traffic.
// The expected result, owner and arrival cycle of every accepted request are
// queued, and a negedge monitor compares them against the response port.
module tb_cmp_lt_slice_scheduler;

    localparam int WIDTH  = 32;
    localparam int SLICE  = 8;
    localparam int NREQ   = 4;
    localparam int IDW    = 2;
    localparam int NSLICE = WIDTH / SLICE;
    localparam int W      = 32 + IDW + 2;

    logic                  clk;
    logic                  rst;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_lt;
    logic                  rsp_eq;
    logic [IDW-1:0]        rsp_id;
    logic                  busy;

    // Expected entries: {due_cycle[31:0], id, lt, eq}
    logic [W-1:0] exp_q[$];

    int n_total;
    int n_pass;
    int cycle;
    int model_ptr;
    bit outstanding;
    int mg;
    logic [NREQ-1:0] exp_ready;
    bit exp_valid;
    bit rand_done;

    cmp_lt_slice_scheduler #(
        .WIDTH(WIDTH), .SLICE(SLICE), .NREQ(NREQ), .IDW(IDW)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .rsp_id(rsp_id),
        .busy(busy)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
    endtask

    // Number of CMP cycles: slices scanned from the MSB until the first
    // differing one, or all of them when the operands match.
    function automatic int cmp_cycles(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        logic [WIDTH-1:0] x;
        int msb;
        x = a ^ b;
        if (x == '0) return NSLICE;
        msb = 0;
        for (int i = 0; i < WIDTH; i++) if (x[i]) msb = i;
        return (WIDTH - 1 - msb) / SLICE + 1;
    endfunction

    // ---------------- scoreboard / monitor ----------------
    always @(negedge clk) begin
        logic [WIDTH-1:0] ea;
        logic [WIDTH-1:0] eb;
        logic [W-1:0]     e;
        int               due;
        cycle++;
        if (rst) begin
            exp_q.delete();
            outstanding = 1'b0;
            model_ptr   = 0;
        end else begin
            exp_ready = '0;
            mg = -1;
            if (!outstanding && (req_valid != '0)) begin
                for (int k = 0; k < NREQ; k++) begin
                    if (mg < 0 && req_valid[(model_ptr + k) % NREQ]) mg = (model_ptr + k) % NREQ;
                end
                exp_ready[mg] = 1'b1;
            end
            chk("req_ready", 64'(req_ready), 64'(exp_ready));
            chk("busy", 64'(busy), 64'(outstanding));
            due = (exp_q.size() > 0) ? int'(exp_q[0][W-1:IDW+2]) : 0;
            exp_valid = outstanding && (exp_q.size() > 0) && (cycle >= due);
            chk("rsp_valid", 64'(rsp_valid), 64'(exp_valid));
            if (!rsp_valid) chk("flags_low_when_idle", 64'({rsp_lt, rsp_eq}), 64'(0));
            if (rsp_valid && exp_valid) begin
                e = exp_q[0];
                chk("rsp_lt", 64'(rsp_lt), 64'(e[1]));
                chk("rsp_eq", 64'(rsp_eq), 64'(e[0]));
                chk("rsp_id", 64'(rsp_id), 64'(e[IDW+1:2]));
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    outstanding = 1'b0;
                end
            end
            if (mg >= 0) begin
                ea = req_a[mg*WIDTH +: WIDTH];
                eb = req_b[mg*WIDTH +: WIDTH];
                e  = {32'(cycle + 1 + cmp_cycles(ea, eb)), IDW'(mg), ea < eb, ea == eb};
                exp_q.push_back(e);
                model_ptr   = (mg + 1) % NREQ;
                outstanding = 1'b1;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Present an operand pair on requester i and hold it until accepted.
    task automatic issue(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bit got;
        @(posedge clk); #1;
        req_a[i*WIDTH +: WIDTH] = a;
        req_b[i*WIDTH +: WIDTH] = b;
        req_valid[i] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 2000 && !got; t++) begin
            @(negedge clk);
            if (req_ready[i]) got = 1'b1;
        end
        if (!got) chk("grant_wait", 64'(got), 64'(1));
        @(posedge clk); #1;
        req_valid[i] = 1'b0;
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 2000 && (outstanding || req_valid != '0); t++) @(negedge clk);
        chk("drain_outstanding", 64'(outstanding), 64'(0));
    endtask

    task automatic rand_issue(input int i);
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] mask;
        int keep;
        repeat ($urandom_range(0, 4)) @(posedge clk);
        if ($urandom_range(0, 3) != 0) begin
            a    = $urandom;
            keep = $urandom_range(0, NSLICE);
            mask = (keep == 0) ? '0 : ~({WIDTH{1'b1}} >> (keep * SLICE));
            if (keep == NSLICE) mask = '1;
            b    = (a & mask) | (WIDTH'($urandom) & ~mask);
            issue(i, a, b);
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        n_total = 0; n_pass = 0; cycle = 0; model_ptr = 0; outstanding = 1'b0;
        rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
        rand_done = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_rsp_id", 64'(rsp_id), 64'(0));

        // Directed single requests: full scan, MSB exit, equal operands.
        issue(0, 32'd5, 32'd7);
        wait_drain();
        issue(2, 32'h8000_0000, 32'h7FFF_FFFF);
        wait_drain();
        issue(1, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        wait_drain();

        // All requesters contending from a fresh pointer: order 0,1,2,3,0,1.
        do_reset();
        fork
            begin issue(0, 32'h0000_0010, 32'h0000_0020); issue(0, 32'h1, 32'h1); end
            begin issue(1, 32'hFF00_0000, 32'h0F00_0000); issue(1, 32'h0, 32'h1); end
            issue(2, 32'h1234_5678, 32'h1234_5678);
            issue(3, 32'h0012_0000, 32'h0013_0000);
        join
        wait_drain();

        // Response back-pressure for 6 cycles with another requester waiting.
        rsp_ready = 1'b0;
        fork
            issue(3, 32'h0000_0001, 32'h0000_0002);
            begin
                repeat (3) @(posedge clk);
                issue(0, 32'h5555_0000, 32'h4444_0000);
            end
            begin
                for (int t = 0; t < 200 && !rsp_valid; t++) @(negedge clk);
                chk("stall_seen_valid", 64'(rsp_valid), 64'(1));
                repeat (6) @(posedge clk);
                #1 rsp_ready = 1'b1;
            end
        join
        wait_drain();

        // Reset during the second CMP cycle; requester 3 waits through it.
        issue(0, 32'h1234_5678, 32'h1200_0000);
        @(posedge clk); #1;
        rst = 1'b1;
        req_a[3*WIDTH +: WIDTH] = 32'hAAAA_0000;
        req_b[3*WIDTH +: WIDTH] = 32'hAAAA_0001;
        req_valid[3] = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("post_reset_rsp_valid", 64'(rsp_valid), 64'(0));
        chk("post_reset_busy", 64'(busy), 64'(0));
        chk("post_reset_grant3", 64'(req_ready), 64'(4'b1000));
        @(posedge clk); #1;
        req_valid[3] = 1'b0;
        wait_drain();

        // Random traffic with random response back-pressure.
        fork
            begin
                for (int r = 0; r < 12; r++) begin
                    fork
                        rand_issue(0);
                        rand_issue(1);
                        rand_issue(2);
                        rand_issue(3);
                    join
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 2) != 0);
                end
            end
        join
        rsp_ready = 1'b1;
        wait_drain();
        repeat (5) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'(0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/cmp_lt_slice_scheduler.md
Name: cmp_lt_slice_scheduler

Overview:
- Shares one unsigned less-than comparison resource among NREQ requesters.
- Selects a requester with a round-robin arbiter and latches its operand pair.
- Evaluates a < b serially, SLICE bits per cycle, starting at the MSB slice and stopping early at the first slice that differs.
- Returns lt/eq flags tagged with the requester index over a valid/ready response port. This is the sequential front-end for the garbled 32-bit comparator datapath.

Parameters:
- WIDTH, 32, operand width in bits; must be a multiple of SLICE.
- SLICE, 8, bits compared per CMP cycle. NSLICE = WIDTH/SLICE.
- NREQ, 4, number of requesters; must be >= 2.
- IDW, 2, requester index width; equals clog2(NREQ).

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  NREQ  bit i: requester i holds a valid operand pair.
- req_ready  output  NREQ  one-hot or zero; bit i: operand pair of requester i accepted this cycle.
- req_a  input  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b; same packing as req_a.
- rsp_valid  output  1  result available.
- rsp_ready  input  1  consumer accepts the result.
- rsp_lt  output  1  1 iff a < b, unsigned.
- rsp_eq  output  1  1 iff a == b.
- rsp_id  output  IDW  index of the requester that owns the result.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset:
  - FSM = IDLE; rr_ptr = 0; slice_idx = NSLICE-1.
  - rsp_valid = 0, rsp_lt = 0, rsp_eq = 0, rsp_id = 0, busy = 0, req_ready = 0.
  - An in-flight comparison is discarded and its result is never presented.
  - Reset overrides every event in the same cycle.
- Requester rule: requester i holds req_valid[i] and its operands stable until req_ready[i] is high. Operand changes before acceptance are not a supported scenario.
- IDLE:
  - If any req_valid bit is set, grant g = first set index scanning rr_ptr, rr_ptr+1, ... mod NREQ.
  - req_ready[g] = 1 combinationally in that cycle.
  - On the edge: a_reg <= a[g], b_reg <= b[g], id_reg <= g, rr_ptr <= (g+1) mod NREQ, slice_idx <= NSLICE-1, FSM -> CMP.
  - With no request, FSM stays in IDLE.
  - req_ready is 0 in every state other than IDLE.
- CMP: compare slice s = slice_idx of a_reg and b_reg, both unsigned.
  - a_s < b_s: lt <= 1, eq <= 0, FSM -> RESP.
  - a_s > b_s: lt <= 0, eq <= 0, FSM -> RESP.
  - Equal and s == 0: lt <= 0, eq <= 1, FSM -> RESP.
  - Equal and s > 0: slice_idx <= s-1, FSM stays in CMP.
- RESP:
  - rsp_valid = 1; rsp_lt, rsp_eq and rsp_id are registered and held stable until the handshake.
  - When rsp_valid && rsp_ready, FSM -> IDLE and rsp_valid falls on the next edge.
  - No new grant is made while in RESP.
- Latency:
  - Acceptance at edge T, first differing slice found after k CMP cycles (1 <= k <= NSLICE): rsp_valid is high from cycle T+1+k.
  - Earliest new acceptance is the cycle after the response handshake.
  - Throughput is at most one comparison per k+2 cycles.
- Outputs: rsp_lt and rsp_eq are never both 1. Both are 0 when rsp_valid = 0.
- Fairness: a continuously asserted request is granted within NREQ grants.

Test Plan:
- Requester 0, a=5, b=7, rsp_ready=1 -> req_ready=0001 for 1 cycle; 4 CMP cycles; rsp_valid 5 cycles after acceptance with lt=1, eq=0, id=0.
- Requester 2, a=0x80000000, b=0x7FFFFFFF -> early exit at the MSB slice; rsp_valid at T+2 with lt=0, eq=0, id=2.
- Requester 1, a=b=0xDEADBEEF -> 4 CMP cycles; lt=0, eq=1, id=1.
- All four requesters held valid, rsp_ready=1 -> grant order 0,1,2,3,0,1; each req_ready bit high exactly once per round.
- RESP with rsp_ready=0 for 6 cycles -> rsp_valid, rsp_lt and rsp_id stable; req_ready=0000; busy=1. rsp_ready=1 -> IDLE next edge, next grant one cycle later.
- rst=1 during the 2nd CMP cycle, then requester 3 valid:
  - After the reset edge: rsp_valid=0, busy=0, rr_ptr=0.
  - The aborted result never appears.
  - Requester 3 is granted in the first cycle after rst deasserts.
